// File: rtl/mem_port_arbiter.sv
// Two-master arbiter for the shared scratch memory port: forwards one master's
// req/gnt/rvalid transaction at a time with no added latency and flags spurious responses.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH = 12,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  m0_req_i,
    input  logic [ADDR_WIDTH-1:0] m0_addr_i,
    input  logic                  m0_we_i,
    input  logic [3:0]            m0_be_i,
    input  logic [31:0]           m0_wdata_i,
    output logic                  m0_gnt_o,
    output logic                  m0_rvalid_o,
    output logic [31:0]           m0_rdata_o,
    input  logic                  m1_req_i,
    input  logic [ADDR_WIDTH-1:0] m1_addr_i,
    input  logic                  m1_we_i,
    input  logic [3:0]            m1_be_i,
    input  logic [31:0]           m1_wdata_i,
    output logic                  m1_gnt_o,
    output logic                  m1_rvalid_o,
    output logic [31:0]           m1_rdata_o,
    output logic                  s_req_o,
    output logic [ADDR_WIDTH-1:0] s_addr_o,
    output logic                  s_we_o,
    output logic [3:0]            s_be_o,
    output logic [31:0]           s_wdata_o,
    input  logic                  s_gnt_i,
    input  logic                  s_rvalid_i,
    input  logic [31:0]           s_rdata_i,
    output logic                  owner_o,
    output logic                  busy_o,
    output logic                  err_o
);

    typedef enum logic {
        IDLE,
        WAIT_RESP
    } state_t;

    state_t state_q;
    logic   owner_q;
    logic   last_q;
    logic   lock_q;
    logic   lock_sel_q;

    logic   sel;
    logic   mux_sel;
    logic   sel_req;
    logic   idle;
    logic   waiting;

    // A held lock pins the choice until the slave grants; otherwise arbitrate.
    always_comb begin
        sel = last_q;
        if (lock_q) begin
            sel = lock_sel_q;
        end else if (m0_req_i && !m1_req_i) begin
            sel = 1'b0;
        end else if (m1_req_i && !m0_req_i) begin
            sel = 1'b1;
        end else if (m0_req_i && m1_req_i) begin
            sel = FIXED_PRIO ? 1'b1 : ~last_q;
        end
    end

    assign idle    = !rst_i && (state_q == IDLE);
    assign waiting = !rst_i && (state_q == WAIT_RESP);
    assign mux_sel = (state_q == WAIT_RESP) ? owner_q : sel;
    assign sel_req = sel ? m1_req_i : m0_req_i;

    assign s_req_o   = idle && sel_req;
    assign s_addr_o  = mux_sel ? m1_addr_i  : m0_addr_i;
    assign s_we_o    = mux_sel ? m1_we_i    : m0_we_i;
    assign s_be_o    = mux_sel ? m1_be_i    : m0_be_i;
    assign s_wdata_o = mux_sel ? m1_wdata_i : m0_wdata_i;

    assign m0_gnt_o    = idle && !sel && s_gnt_i;
    assign m1_gnt_o    = idle &&  sel && s_gnt_i;
    assign m0_rvalid_o = waiting && !owner_q && s_rvalid_i;
    assign m1_rvalid_o = waiting &&  owner_q && s_rvalid_i;
    assign m0_rdata_o  = s_rdata_i;
    assign m1_rdata_o  = s_rdata_i;

    assign busy_o  = waiting;
    assign owner_o = !rst_i && owner_q;

    // last_q resets to 1 so master 0 wins the first contested cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            owner_q    <= 1'b0;
            last_q     <= 1'b1;
            lock_q     <= 1'b0;
            lock_sel_q <= 1'b0;
            err_o      <= 1'b0;
        end else begin
            err_o <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (s_rvalid_i) begin
                        err_o <= 1'b1;
                    end
                    if (sel_req && s_gnt_i) begin
                        owner_q <= sel;
                        last_q  <= sel;
                        lock_q  <= 1'b0;
                        state_q <= WAIT_RESP;
                    end else if (sel_req) begin
                        lock_q     <= 1'b1;
                        lock_sel_q <= sel;
                    end else begin
                        // The locked master dropped its request before grant.
                        lock_q <= 1'b0;
                    end
                end
                WAIT_RESP: begin
                    if (s_rvalid_i) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
